// File: rtl/flag_channel_arbiter.sv
// Round-robin scheduler feeding a toggle-based flag crossing.
// Issues one spaced flag pulse per pending requester with a stable ID.
module flag_channel_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int GAP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            clear_ovf,
  output logic            grant_flag,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] overflow,
  output logic            busy
);

  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLAG = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic            found;
  logic            take;
  logic [NREQ-1:0] clr;
  logic [2*NREQ-1:0] dbl;

  // Rotate pending so the search starts at ptr; first set bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    dbl   = {pending, pending} >> ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Next state; a finished hold-off chains straight into the next flag.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    unique case (state)
      IDLE: take = found;
      FLAG: begin
        if (GAP == 1) begin
          if (found) take = 1'b1;
          else       state_n = IDLE;
        end else begin
          cnt_n   = CW'(GAP - 1);
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (found) take = 1'b1;
          else       state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) state_n = FLAG;
  end

  assign clr  = take ? (NREQ'(1) << win) : '0;
  assign busy = (state != IDLE);

  // State, registered outputs, pending latch and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      grant_flag <= 1'b0;
      grant_id   <= '0;
      pending    <= '0;
      overflow   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant_flag <= take;
      if (take) begin
        grant_id <= win;
        ptr      <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
      pending  <= (pending & ~clr) | req;
      overflow <= (clear_ovf ? '0 : overflow)
                | (req & pending & ~clr);
    end
  end

endmodule

// File: tb/tb_flag_channel_arbiter.sv
// Self-checking bench for flag_channel_arbiter (NREQ=4, GAP=4).
// Per-scenario stimulus and expectation tables, scoreboard queue.
module tb_flag_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       clear_ovf;
  logic       grant_flag;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       busy;

  always #5 clk = ~clk;

  flag_channel_arbiter #(
    .NREQ(4),
    .IDW (2),
    .GAP (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .clear_ovf (clear_ovf),
    .grant_flag(grant_flag),
    .grant_id  (grant_id),
    .pending   (pending),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef enum int {K_FLAG, K_ID, K_PEND, K_OVF, K_BUSY} kind_e;

  typedef struct {
    int         sc;
    int         cyc;
    logic       rs;
    logic [3:0] rq;
    logic       cl;
  } stim_t;

  typedef struct {
    int         sc;
    int         lo;
    int         hi;
    kind_e      k;
    logic [3:0] v;
  } chk_t;

  stim_t stims[$];
  chk_t  chks[$];
  chk_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    w;
  logic  seen;

  function automatic void s(int sc, int cyc, logic rs,
                            logic [3:0] rq, logic cl);
    stim_t t;
    t.sc = sc; t.cyc = cyc; t.rs = rs; t.rq = rq; t.cl = cl;
    stims.push_back(t);
  endfunction

  function automatic void e(int sc, int lo, int hi,
                            kind_e k, logic [3:0] v);
    chk_t t;
    t.sc = sc; t.lo = lo; t.hi = hi; t.k = k; t.v = v;
    chks.push_back(t);
  endfunction

  function automatic logic [3:0] act(kind_e k);
    case (k)
      K_FLAG:  return {3'b0, grant_flag};
      K_ID:    return {2'b0, grant_id};
      K_PEND:  return pending;
      K_OVF:   return overflow;
      default: return {3'b0, busy};
    endcase
  endfunction

  initial begin
    s(1, 0, 1'b0, 4'b1111, 1'b0);
    s(1, 1, 1'b0, 4'b1111, 1'b0);
    s(1, 2, 1'b0, 4'b1111, 1'b0);
    e(1, 1, 9, K_FLAG, 4'd0);
    e(1, 1, 9, K_ID,   4'd0);
    e(1, 1, 9, K_PEND, 4'd0);
    e(1, 1, 9, K_OVF,  4'd0);
    e(1, 1, 9, K_BUSY, 4'd0);
    s(2, 10, 1'b0, 4'b0100, 1'b0);
    e(2, 1, 10, K_PEND, 4'd0);
    e(2, 11, 11, K_PEND, 4'b0100);
    e(2, 12, 30, K_PEND, 4'd0);
    e(2, 1, 11, K_FLAG, 4'd0);
    e(2, 12, 12, K_FLAG, 4'd1);
    e(2, 13, 39, K_FLAG, 4'd0);
    e(2, 12, 39, K_ID, 4'd2);
    e(2, 1, 11, K_BUSY, 4'd0);
    e(2, 12, 16, K_BUSY, 4'd1);
    e(2, 17, 39, K_BUSY, 4'd0);
    s(3, 10, 1'b0, 4'b1111, 1'b0);
    e(3, 11, 11, K_PEND, 4'b1111);
    e(3, 12, 16, K_PEND, 4'b1110);
    e(3, 17, 21, K_PEND, 4'b1100);
    e(3, 22, 26, K_PEND, 4'b1000);
    e(3, 27, 39, K_PEND, 4'd0);
    e(3, 12, 12, K_FLAG, 4'd1);
    e(3, 13, 16, K_FLAG, 4'd0);
    e(3, 17, 17, K_FLAG, 4'd1);
    e(3, 22, 22, K_FLAG, 4'd1);
    e(3, 27, 27, K_FLAG, 4'd1);
    e(3, 28, 39, K_FLAG, 4'd0);
    e(3, 12, 16, K_ID, 4'd0);
    e(3, 17, 21, K_ID, 4'd1);
    e(3, 22, 26, K_ID, 4'd2);
    e(3, 27, 39, K_ID, 4'd3);
    e(3, 12, 31, K_BUSY, 4'd1);
    e(3, 32, 39, K_BUSY, 4'd0);
    s(4, 10, 1'b0, 4'b0010, 1'b0);
    s(4, 12, 1'b0, 4'b0011, 1'b0);
    s(4, 14, 1'b0, 4'b0001, 1'b0);
    s(4, 20, 1'b0, 4'b0000, 1'b1);
    s(4, 24, 1'b0, 4'b0100, 1'b0);
    s(4, 25, 1'b0, 4'b0100, 1'b1);
    e(4, 12, 12, K_FLAG, 4'd1);
    e(4, 12, 16, K_ID, 4'd1);
    e(4, 13, 16, K_PEND, 4'b0011);
    e(4, 11, 14, K_OVF, 4'd0);
    e(4, 15, 20, K_OVF, 4'b0001);
    e(4, 21, 25, K_OVF, 4'd0);
    e(4, 26, 39, K_OVF, 4'b0100);
    e(4, 17, 17, K_FLAG, 4'd1);
    e(4, 17, 21, K_ID, 4'd0);
    e(4, 17, 21, K_PEND, 4'b0010);
    e(4, 22, 22, K_FLAG, 4'd1);
    e(4, 22, 26, K_ID, 4'd1);
    e(4, 22, 24, K_PEND, 4'd0);
    e(4, 25, 26, K_PEND, 4'b0100);
    e(4, 27, 27, K_FLAG, 4'd1);
    e(4, 27, 39, K_ID, 4'd2);
    e(4, 27, 39, K_PEND, 4'd0);
    s(5, 10, 1'b0, 4'b1000, 1'b0);
    s(5, 14, 1'b0, 4'b1001, 1'b0);
    e(5, 12, 12, K_FLAG, 4'd1);
    e(5, 12, 16, K_ID, 4'd3);
    e(5, 15, 16, K_PEND, 4'b1001);
    e(5, 17, 17, K_FLAG, 4'd1);
    e(5, 17, 21, K_ID, 4'd0);
    e(5, 17, 21, K_PEND, 4'b1000);
    e(5, 22, 22, K_FLAG, 4'd1);
    e(5, 22, 39, K_ID, 4'd3);
    e(5, 23, 39, K_FLAG, 4'd0);
    e(5, 27, 39, K_BUSY, 4'd0);
    s(6, 10, 1'b0, 4'b0011, 1'b0);
    s(6, 14, 1'b1, 4'b0000, 1'b0);
    e(6, 12, 12, K_FLAG, 4'd1);
    e(6, 12, 14, K_ID, 4'd0);
    e(6, 12, 14, K_PEND, 4'b0010);
    e(6, 12, 14, K_BUSY, 4'd1);
    e(6, 15, 39, K_PEND, 4'd0);
    e(6, 15, 39, K_FLAG, 4'd0);
    e(6, 15, 39, K_BUSY, 4'd0);
    e(6, 15, 39, K_ID, 4'd0);
    s(7, 10, 1'b0, 4'b0100, 1'b0);
    s(7, 11, 1'b0, 4'b0100, 1'b0);
    e(7, 11, 16, K_PEND, 4'b0100);
    e(7, 17, 39, K_PEND, 4'd0);
    e(7, 11, 39, K_OVF, 4'd0);
    e(7, 12, 12, K_FLAG, 4'd1);
    e(7, 13, 16, K_FLAG, 4'd0);
    e(7, 17, 17, K_FLAG, 4'd1);
    e(7, 18, 39, K_FLAG, 4'd0);
    e(7, 12, 39, K_ID, 4'd2);
    e(7, 12, 21, K_BUSY, 4'd1);
    e(7, 22, 39, K_BUSY, 4'd0);

    rst       = 1'b1;
    req       = '0;
    clear_ovf = 1'b0;

    for (int sc = 1; sc <= 7; sc++) begin
      sb.delete();
      foreach (chks[i]) if (chks[i].sc == sc) sb.push_back(chks[i]);
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        rst       = (c < 3);
        req       = '0;
        clear_ovf = 1'b0;
        foreach (stims[i]) begin
          if (stims[i].sc == sc && stims[i].cyc == c) begin
            rst       = rst | stims[i].rs;
            req       = req | stims[i].rq;
            clear_ovf = clear_ovf | stims[i].cl;
          end
        end
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (c >= sb[i].lo && c <= sb[i].hi) begin
            n_cmp++;
            if (act(sb[i].k) !== sb[i].v) begin
              n_bad++;
              $display("FAIL sc%0d cyc%0d %s: got %b want %b",
                       sc, c, sb[i].k.name(), act(sb[i].k), sb[i].v);
            end
          end
          if (c >= sb[i].hi) sb.delete(i);
        end
      end
    end

    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 4'b1111;
      clear_ovf = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({grant_flag, grant_id, pending, overflow, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset state: flag=%b id=%b pend=%b ovf=%b busy=%b",
               grant_flag, grant_id, pending, overflow, busy);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0100;
    @(posedge clk);
    #1;
    req = '0;
    seen = 1'b0;
    w = 0;
    while (!seen && w < 10) begin
      @(negedge clk);
      if (grant_flag) seen = 1'b1;
      else w++;
    end
    n_cmp++;
    if (!seen || grant_id !== 2'd2) begin
      n_bad++;
      $display("FAIL wait for flag: seen=%b id=%0d after %0d cycles",
               seen, grant_id, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
